// File: rtl/alien_bomb_move_collision.sv
// alien_bomb_move_collision
//   Downward alien bomb generator. After a frame-counted cooldown it picks a
//   random living alien column, looks up the lowest live row in that column,
//   spawns a bomb underneath it and moves the bomb down once per frame in
//   x64 fixed point until it collides or reaches the screen bottom.
//
//   Optional build macro: ALIEN_BOMB_ACCEL_EN
//     defined   - bomb speed grows by 8 per frame, saturating at MAX_Y_SPEED
//     undefined - bomb speed is constant at INITIAL_Y_SPEED
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   startOfFrame     one-cycle pulse per video frame
//   playGame         game running; low forces idle
//   bombCollision    bomb hit player/shield (only honoured while flying)
//   alienBaseX/Y     signed top-left pixel of the alien matrix
//   aliveColumns     bit c set = column c has a live alien
//   colRowIdx        lowest live row of colReq (valid one cycle after colReq)
//   colReq           column being queried
//   topLeftX/Y       bomb top-left pixel position
//   alive            bomb is flying and must be drawn
//   newBomb          one-cycle pulse on spawn
module alien_bomb_move_collision #(
    parameter int INITIAL_Y_SPEED = 192,
    parameter int MAX_Y_SPEED     = 448,
    parameter int COOLDOWN_FRAMES = 45,
    parameter int BOTTOM_Y        = 470,
    parameter int BOMB_X_OFFSET   = 28,
    parameter int BOMB_Y_OFFSET   = 40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               playGame,
    input  logic               bombCollision,
    input  logic signed [10:0] alienBaseX,
    input  logic signed [10:0] alienBaseY,
    input  logic        [7:0]  aliveColumns,
    input  logic        [2:0]  colRowIdx,
    output logic        [2:0]  colReq,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               alive,
    output logic               newBomb
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COOLDOWN,
        S_SELECT,
        S_LOOKUP,
        S_FLYING
    } state_t;

    localparam logic [15:0] CD_LAST   = 16'(COOLDOWN_FRAMES - 1);
    localparam logic [7:0]  LFSR_SEED = 8'hA5;

    if (COOLDOWN_FRAMES < 1 || MAX_Y_SPEED < INITIAL_Y_SPEED) begin : g_param_check
        $error("alien_bomb_move_collision: bad COOLDOWN_FRAMES or MAX_Y_SPEED");
    end

    state_t             state_q, state_d;
    logic        [7:0]  lfsr_q, lfsr_d;
    logic        [15:0] cnt_q, cnt_d;
    logic        [2:0]  cand_q, cand_d;
    logic        [2:0]  miss_q, miss_d;
    logic               wait_q, wait_d;
    logic        [2:0]  col_req_q, col_req_d;
    logic signed [31:0] pos_x_q, pos_x_d;
    logic signed [31:0] pos_y_q, pos_y_d;
    logic signed [31:0] speed_q, speed_d;
    logic               alive_q, alive_d;
    logic               new_bomb_q, new_bomb_d;

    logic               lfsr_fb;
    logic signed [31:0] base_x, base_y, col_off, row_off;
    logic signed [31:0] spawn_x, spawn_y, next_y;
`ifdef ALIEN_BOMB_ACCEL_EN
    logic signed [31:0] speed_sum;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        miss_d     = miss_q;
        wait_d     = wait_q;
        col_req_d  = col_req_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        speed_d    = speed_q;
        alive_d    = alive_q;
        new_bomb_d = 1'b0;

        // Fibonacci LFSR for x^8+x^6+x^5+x^4+1; free-running in every state
        lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        lfsr_d  = {lfsr_q[6:0], lfsr_fb};

        base_x  = {{21{alienBaseX[10]}}, alienBaseX};
        base_y  = {{21{alienBaseY[10]}}, alienBaseY};
        col_off = {23'd0, col_req_q, 6'd0};                            // col * 64
        row_off = {24'd0, colRowIdx, 5'd0} + {25'd0, colRowIdx, 4'd0}; // row * 48
        spawn_x = base_x + col_off + BOMB_X_OFFSET;
        spawn_y = base_y + row_off + BOMB_Y_OFFSET;
        next_y  = pos_y_q + speed_q;
`ifdef ALIEN_BOMB_ACCEL_EN
        speed_sum = speed_q + 32'sd8;
`endif

        if (!playGame) begin
            state_d = S_IDLE;
            alive_d = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_COOLDOWN;

                S_COOLDOWN: begin
                    if (startOfFrame) begin
                        if (cnt_q == CD_LAST) begin
                            cnt_d   = '0;
                            cand_d  = lfsr_q[2:0];
                            miss_d  = '0;
                            state_d = S_SELECT;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end

                // Linear probe from the random start column; eight misses
                // means no column is alive, so give up for this cooldown.
                S_SELECT: begin
                    if (aliveColumns[cand_q]) begin
                        col_req_d = cand_q;
                        wait_d    = 1'b1;
                        state_d   = S_LOOKUP;
                    end else begin
                        cand_d = cand_q + 3'd1;
                        miss_d = miss_q + 3'd1;
                        if (miss_q == 3'd7) begin
                            state_d = S_COOLDOWN;
                        end
                    end
                end

                // First cycle lets the matrix answer colReq; spawn on the second.
                S_LOOKUP: begin
                    if (wait_q) begin
                        wait_d = 1'b0;
                    end else begin
                        pos_x_d    = spawn_x <<< 6;
                        pos_y_d    = spawn_y <<< 6;
                        speed_d    = INITIAL_Y_SPEED;
                        alive_d    = 1'b1;
                        new_bomb_d = 1'b1;
                        state_d    = S_FLYING;
                    end
                end

                S_FLYING: begin
                    if (bombCollision) begin
                        alive_d = 1'b0;
                        state_d = S_COOLDOWN;
                    end else if (startOfFrame) begin
                        pos_y_d = next_y;
`ifdef ALIEN_BOMB_ACCEL_EN
                        speed_d = (speed_sum > MAX_Y_SPEED) ? MAX_Y_SPEED : speed_sum;
`endif
                        if ((next_y >>> 6) >= BOTTOM_Y) begin
                            alive_d = 1'b0;
                            state_d = S_COOLDOWN;
                        end
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lfsr_q     <= LFSR_SEED;
            cnt_q      <= '0;
            cand_q     <= '0;
            miss_q     <= '0;
            wait_q     <= 1'b0;
            col_req_q  <= '0;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            speed_q    <= INITIAL_Y_SPEED;
            alive_q    <= 1'b0;
            new_bomb_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            miss_q     <= miss_d;
            wait_q     <= wait_d;
            col_req_q  <= col_req_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            speed_q    <= speed_d;
            alive_q    <= alive_d;
            new_bomb_q <= new_bomb_d;
        end
    end

    // X never moves, so only its pixel bits are visible
    logic unused_x_bits;
    assign unused_x_bits = ^{pos_x_q[31:17], pos_x_q[5:0]};

    assign colReq   = col_req_q;
    assign topLeftX = pos_x_q[16:6];
    assign topLeftY = pos_y_q[16:6];
    assign alive    = alive_q;
    assign newBomb  = new_bomb_q;

endmodule
